// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the dual-issue scoreboard stage.
package issue_scoreboard_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    ISSUE_PAIR = 1'b0,
    HOLD_B     = 1'b1
  } issue_state_t;
endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode / writeback / execute signal bundle for issue_scoreboard.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic      pair_valid_i;
  logic      pair_ready_o;
  logic      A_valid_i;
  logic      B_valid_i;
  reg_addr_t A_rs1_addr_i;
  reg_addr_t A_rs2_addr_i;
  reg_addr_t A_rd_addr_i;
  logic      A_rd_write_i;
  reg_addr_t B_rs1_addr_i;
  reg_addr_t B_rs2_addr_i;
  reg_addr_t B_rd_addr_i;
  logic      B_rd_write_i;
  logic      exec_stall_i;
  logic      flush_i;
  reg_addr_t A_wb_addr_i;
  reg_addr_t B_wb_addr_i;
  logic      A_wb_write_i;
  logic      B_wb_write_i;
  logic      A_issue_o;
  logic      B_issue_o;
  reg_addr_t A_rs1_addr_o;
  reg_addr_t A_rs2_addr_o;
  reg_addr_t B_rs1_addr_o;
  reg_addr_t B_rs2_addr_o;
  logic      A_ex_valid_o;
  logic      B_ex_valid_o;
  reg_addr_t A_ex_rd_o;
  reg_addr_t B_ex_rd_o;
  logic      A_ex_rd_write_o;
  logic      B_ex_rd_write_o;

  modport master (
    output pair_valid_i, A_valid_i, B_valid_i,
           A_rs1_addr_i, A_rs2_addr_i, A_rd_addr_i, A_rd_write_i,
           B_rs1_addr_i, B_rs2_addr_i, B_rd_addr_i, B_rd_write_i,
           exec_stall_i, flush_i,
           A_wb_addr_i, B_wb_addr_i, A_wb_write_i, B_wb_write_i,
    input  pair_ready_o, A_issue_o, B_issue_o,
           A_rs1_addr_o, A_rs2_addr_o, B_rs1_addr_o, B_rs2_addr_o,
           A_ex_valid_o, B_ex_valid_o, A_ex_rd_o, B_ex_rd_o,
           A_ex_rd_write_o, B_ex_rd_write_o
  );

  modport slave (
    input  pair_valid_i, A_valid_i, B_valid_i,
           A_rs1_addr_i, A_rs2_addr_i, A_rd_addr_i, A_rd_write_i,
           B_rs1_addr_i, B_rs2_addr_i, B_rd_addr_i, B_rd_write_i,
           exec_stall_i, flush_i,
           A_wb_addr_i, B_wb_addr_i, A_wb_write_i, B_wb_write_i,
    output pair_ready_o, A_issue_o, B_issue_o,
           A_rs1_addr_o, A_rs2_addr_o, B_rs1_addr_o, B_rs2_addr_o,
           A_ex_valid_o, B_ex_valid_o, A_ex_rd_o, B_ex_rd_o,
           A_ex_rd_write_o, B_ex_rd_write_o
  );
endinterface

// File: rtl/issue_scoreboard_hazard_check.sv
// Per-slot RAW/WAW check against the effective busy vector; x0 never hazards.
module issue_hazard_check
  import issue_scoreboard_pkg::*;
(
  input  reg_addr_t           i_rs1,
  input  reg_addr_t           i_rs2,
  input  reg_addr_t           i_rd,
  input  logic                i_rd_write,
  input  logic [NUM_REGS-1:0] i_busy_eff,
  output logic                o_hazard
);
  logic w_rs1_haz;
  logic w_rs2_haz;
  logic w_rd_haz;

  assign w_rs1_haz = (i_rs1 != '0) && i_busy_eff[i_rs1];
  assign w_rs2_haz = (i_rs2 != '0) && i_busy_eff[i_rs2];
  assign w_rd_haz  = i_rd_write && (i_rd != '0) && i_busy_eff[i_rd];
  assign o_hazard  = w_rs1_haz || w_rs2_haz || w_rd_haz;
endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue stage: busy scoreboard, in-order A/B issue decision, and
// execute-valid strobes registered to line up with register-file read data.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ISSUE_PAIR | both slots of the presented pair are still live
//   HOLD_B     | A already issued; only B remains, A inputs ignored
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_n_i,
  issue_scoreboard_if.slave bus
);
  issue_state_t        r_state;
  issue_state_t        w_next_state;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic                w_en;
  logic                w_haz_a;
  logic                w_haz_b;
  logic                w_intra;
  logic                w_a_issue;
  logic                w_b_issue;
  logic                w_pair_ready;
  logic                r_a_ex_valid;
  logic                r_b_ex_valid;
  reg_addr_t           r_a_ex_rd;
  reg_addr_t           r_b_ex_rd;
  logic                r_a_ex_rd_write;
  logic                r_b_ex_rd_write;

  // Writeback data bypasses into the same-cycle read, so clears unblock now.
  always_comb begin
    w_clr_mask = '0;
    if (bus.A_wb_write_i && (bus.A_wb_addr_i != '0)) w_clr_mask[bus.A_wb_addr_i] = 1'b1;
    if (bus.B_wb_write_i && (bus.B_wb_addr_i != '0)) w_clr_mask[bus.B_wb_addr_i] = 1'b1;
  end

  assign w_busy_eff = r_busy & ~w_clr_mask;
  assign w_en       = bus.pair_valid_i && !bus.exec_stall_i && !bus.flush_i;

  issue_hazard_check u_haz_a (
    .i_rs1      (bus.A_rs1_addr_i),
    .i_rs2      (bus.A_rs2_addr_i),
    .i_rd       (bus.A_rd_addr_i),
    .i_rd_write (bus.A_rd_write_i),
    .i_busy_eff (w_busy_eff),
    .o_hazard   (w_haz_a)
  );

  issue_hazard_check u_haz_b (
    .i_rs1      (bus.B_rs1_addr_i),
    .i_rs2      (bus.B_rs2_addr_i),
    .i_rd       (bus.B_rd_addr_i),
    .i_rd_write (bus.B_rd_write_i),
    .i_busy_eff (w_busy_eff),
    .o_hazard   (w_haz_b)
  );

  assign w_intra = bus.A_valid_i && bus.A_rd_write_i && (bus.A_rd_addr_i != '0) &&
                   ((bus.A_rd_addr_i == bus.B_rs1_addr_i) ||
                    (bus.A_rd_addr_i == bus.B_rs2_addr_i) ||
                    (bus.B_rd_write_i && (bus.A_rd_addr_i == bus.B_rd_addr_i)));

  always_comb begin
    w_a_issue    = 1'b0;
    w_b_issue    = 1'b0;
    w_pair_ready = 1'b0;
    w_next_state = r_state;
    if (!reset_n_i) begin
      w_next_state = ISSUE_PAIR;
    end else if (bus.flush_i) begin
      w_pair_ready = 1'b1;
      w_next_state = ISSUE_PAIR;
    end else begin
      case (r_state)
        ISSUE_PAIR: begin
          w_a_issue    = w_en && bus.A_valid_i && !w_haz_a;
          w_b_issue    = w_en && bus.B_valid_i && !w_haz_b && !w_intra &&
                         (w_a_issue || !bus.A_valid_i);
          w_pair_ready = w_en && (w_a_issue || !bus.A_valid_i) &&
                         (w_b_issue || !bus.B_valid_i);
          if (w_a_issue && bus.B_valid_i && !w_b_issue) w_next_state = HOLD_B;
        end
        HOLD_B: begin
          w_b_issue    = w_en && bus.B_valid_i && !w_haz_b;
          w_pair_ready = w_en && (w_b_issue || !bus.B_valid_i);
          if (w_pair_ready) w_next_state = ISSUE_PAIR;
        end
        default: w_next_state = ISSUE_PAIR;
      endcase
    end
  end

  always_comb begin
    w_set_mask = '0;
    if (w_a_issue && bus.A_rd_write_i && (bus.A_rd_addr_i != '0)) w_set_mask[bus.A_rd_addr_i] = 1'b1;
    if (w_b_issue && bus.B_rd_write_i && (bus.B_rd_addr_i != '0)) w_set_mask[bus.B_rd_addr_i] = 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= ISSUE_PAIR;
      r_busy          <= '0;
      r_a_ex_valid    <= 1'b0;
      r_b_ex_valid    <= 1'b0;
      r_a_ex_rd       <= '0;
      r_b_ex_rd       <= '0;
      r_a_ex_rd_write <= 1'b0;
      r_b_ex_rd_write <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_busy          <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_a_ex_valid    <= w_a_issue;
      r_b_ex_valid    <= w_b_issue;
      r_a_ex_rd_write <= w_a_issue && bus.A_rd_write_i;
      r_b_ex_rd_write <= w_b_issue && bus.B_rd_write_i;
      if (w_a_issue) r_a_ex_rd <= bus.A_rd_addr_i;
      if (w_b_issue) r_b_ex_rd <= bus.B_rd_addr_i;
    end
  end

  assign bus.A_issue_o       = w_a_issue;
  assign bus.B_issue_o       = w_b_issue;
  assign bus.pair_ready_o    = w_pair_ready;
  assign bus.A_rs1_addr_o    = bus.A_rs1_addr_i;
  assign bus.A_rs2_addr_o    = bus.A_rs2_addr_i;
  assign bus.B_rs1_addr_o    = bus.B_rs1_addr_i;
  assign bus.B_rs2_addr_o    = bus.B_rs2_addr_i;
  assign bus.A_ex_valid_o    = r_a_ex_valid;
  assign bus.B_ex_valid_o    = r_b_ex_valid;
  assign bus.A_ex_rd_o       = r_a_ex_rd;
  assign bus.B_ex_rd_o       = r_b_ex_rd;
  assign bus.A_ex_rd_write_o = r_a_ex_rd_write;
  assign bus.B_ex_rd_write_o = r_b_ex_rd_write;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed scenarios then random pairs.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if bus();
  issue_scoreboard dut (.clock_i(clk), .reset_n_i(rst_n), .bus(bus));

  typedef struct {
    bit av; int a1; int a2; int ad; bit aw;
    bit bv; int b1; int b2; int bd; bit bw;
  } pair_t;
  typedef struct { int tag; int rd; bit wr; } exp_t;

  pair_t cur;
  exp_t  qa[$];
  exp_t  qb[$];
  exp_t  me;
  int    total = 0;
  int    bad = 0;
  int    mon_cyc = 0;
  bit    mon_en = 0;
  bit    busy[NUM_REGS];
  bit    hold = 0;
  bit    last_ready = 0;
  bit    s_aw, s_bw;
  int    s_aa, s_ba;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mon_cyc);
    end
  endtask

  function automatic pair_t mk(input bit av, input int a1, input int a2, input int ad, input bit aw,
                               input bit bv, input int b1, input int b2, input int bd, input bit bw);
    pair_t p;
    p.av = av; p.a1 = a1; p.a2 = a2; p.ad = ad; p.aw = aw;
    p.bv = bv; p.b1 = b1; p.b2 = b2; p.bd = bd; p.bw = bw;
    return p;
  endfunction

  function automatic pair_t rand_pair();
    pair_t p;
    p.av = ($urandom_range(0, 9) != 0);
    p.a1 = $urandom_range(0, 7); p.a2 = $urandom_range(0, 7); p.ad = $urandom_range(0, 7);
    p.aw = p.av && ($urandom_range(0, 3) != 0);
    p.bv = ($urandom_range(0, 9) != 0);
    p.b1 = $urandom_range(0, 7); p.b2 = $urandom_range(0, 7); p.bd = $urandom_range(0, 7);
    p.bw = ($urandom_range(0, 3) != 0);
    return p;
  endfunction

  // A register is still pending if recorded busy and not written back this cycle.
  function automatic bit pend(input int r);
    bit wb_now;
    wb_now = (s_aw && s_aa == r) || (s_bw && s_ba == r);
    return (r != 0) && busy[r] && !wb_now;
  endfunction

  function automatic bit blocked(input int r1, input int r2, input int rd, input bit w);
    return pend(r1) || pend(r2) || (w && pend(rd));
  endfunction

  task automatic run_cycle(input bit pv, input bit stall, input bit flush,
                           input bit aw, input int aa, input bit bw, input int ba);
    bit en, ea, eb, er, dep, nhold;
    @(negedge clk);
    bus.pair_valid_i = pv;  bus.exec_stall_i = stall;  bus.flush_i = flush;
    bus.A_valid_i    = cur.av;
    bus.A_rs1_addr_i = reg_addr_t'(cur.a1); bus.A_rs2_addr_i = reg_addr_t'(cur.a2);
    bus.A_rd_addr_i  = reg_addr_t'(cur.ad); bus.A_rd_write_i = cur.aw;
    bus.B_valid_i    = cur.bv;
    bus.B_rs1_addr_i = reg_addr_t'(cur.b1); bus.B_rs2_addr_i = reg_addr_t'(cur.b2);
    bus.B_rd_addr_i  = reg_addr_t'(cur.bd); bus.B_rd_write_i = cur.bw;
    bus.A_wb_write_i = aw; bus.A_wb_addr_i = reg_addr_t'(aa);
    bus.B_wb_write_i = bw; bus.B_wb_addr_i = reg_addr_t'(ba);
    s_aw = aw; s_aa = aa; s_bw = bw; s_ba = ba;
    #1;
    en = pv && !stall && !flush;
    ea = 0; eb = 0; er = 0; nhold = hold;
    if (flush) begin
      er = 1; nhold = 0;
    end else if (hold) begin
      eb = en && cur.bv && !blocked(cur.b1, cur.b2, cur.bd, cur.bw);
      er = en && (!cur.bv || eb);
      if (er) nhold = 0;
    end else begin
      dep = cur.av && cur.aw && cur.ad != 0 &&
            (cur.ad == cur.b1 || cur.ad == cur.b2 || (cur.bw && cur.ad == cur.bd));
      ea = en && cur.av && !blocked(cur.a1, cur.a2, cur.ad, cur.aw);
      eb = en && cur.bv && !blocked(cur.b1, cur.b2, cur.bd, cur.bw) && !dep && (ea || !cur.av);
      er = en && (!cur.av || ea) && (!cur.bv || eb);
      nhold = ea && cur.bv && !eb;
    end
    chk("A_issue", int'(bus.A_issue_o), int'(ea));
    chk("B_issue", int'(bus.B_issue_o), int'(eb));
    chk("pair_ready", int'(bus.pair_ready_o), int'(er));
    chk("A_rs2_rd_addr", int'(bus.A_rs2_addr_o), cur.a2);
    chk("B_rs1_rd_addr", int'(bus.B_rs1_addr_o), cur.b1);
    if (ea) qa.push_back('{tag: mon_cyc + 1, rd: cur.ad, wr: cur.aw});
    if (eb) qb.push_back('{tag: mon_cyc + 1, rd: cur.bd, wr: cur.bw});
    if (aw && aa != 0) busy[aa] = 0;
    if (bw && ba != 0) busy[ba] = 0;
    if (ea && cur.aw && cur.ad != 0) busy[cur.ad] = 1;
    if (eb && cur.bw && cur.bd != 0) busy[cur.bd] = 1;
    hold = nhold;
    last_ready = er;
  endtask

  task automatic idle_inputs();
    bus.pair_valid_i = 0; bus.exec_stall_i = 0; bus.flush_i = 0;
    bus.A_wb_write_i = 0; bus.B_wb_write_i = 0;
    bus.A_wb_addr_i = '0; bus.B_wb_addr_i = '0;
  endtask

  // Optionally present a B writeback just before reset so B would otherwise issue.
  task automatic do_reset(input bit pre_wb, input int wb_addr);
    @(posedge clk); #3;
    if (pre_wb) begin
      bus.B_wb_write_i = 1; bus.B_wb_addr_i = reg_addr_t'(wb_addr);
    end
    #1;
    rst_n = 0;
    mon_en = 1;
    #1;
    chk("rst_A_issue", int'(bus.A_issue_o), 0);
    chk("rst_B_issue", int'(bus.B_issue_o), 0);
    chk("rst_pair_ready", int'(bus.pair_ready_o), 0);
    chk("rst_A_ex_valid", int'(bus.A_ex_valid_o), 0);
    chk("rst_B_ex_valid", int'(bus.B_ex_valid_o), 0);
    chk("rst_A_ex_rd", int'(bus.A_ex_rd_o), 0);
    chk("rst_B_ex_rd", int'(bus.B_ex_rd_o), 0);
    chk("rst_A_ex_rd_write", int'(bus.A_ex_rd_write_o), 0);
    chk("rst_B_ex_rd_write", int'(bus.B_ex_rd_write_o), 0);
    idle_inputs();
    for (int r = 0; r < NUM_REGS; r++) busy[r] = 0;
    hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (mon_en) begin
      if (qa.size() > 0 && qa[0].tag == mon_cyc) begin
        me = qa.pop_front();
        chk("A_ex_valid", int'(bus.A_ex_valid_o), 1);
        chk("A_ex_rd", int'(bus.A_ex_rd_o), me.rd);
        chk("A_ex_rd_write", int'(bus.A_ex_rd_write_o), int'(me.wr));
      end else begin
        chk("A_ex_valid_idle", int'(bus.A_ex_valid_o), 0);
      end
      if (qb.size() > 0 && qb[0].tag == mon_cyc) begin
        me = qb.pop_front();
        chk("B_ex_valid", int'(bus.B_ex_valid_o), 1);
        chk("B_ex_rd", int'(bus.B_ex_rd_o), me.rd);
        chk("B_ex_rd_write", int'(bus.B_ex_rd_write_o), int'(me.wr));
      end else begin
        chk("B_ex_valid_idle", int'(bus.B_ex_valid_o), 0);
      end
    end
  end

  initial begin
    bit need_new;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    do_reset(0, 0);

    // independent pair
    cur = mk(1, 2, 3, 1, 1, 1, 5, 6, 4, 1);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    // B reads A's rd: hold, wait, stall, release on writeback of x7
    cur = mk(1, 10, 11, 7, 1, 1, 7, 0, 13, 1);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 1, 7, 0, 0);
    // A source x9 busy; B writeback of x9 frees both
    cur = mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    cur = mk(1, 2, 9, 14, 1, 1, 15, 16, 17, 1);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 1, 9);
    // set wins over same-cycle clear; x0 and non-busy x8 writebacks are no-ops
    cur = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 1, 5, 0, 0);
    cur = mk(1, 5, 0, 18, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 1, 0, 1, 8);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 1, 5, 0, 0);
    // flush while holding B; A's rd stays busy
    cur = mk(1, 0, 0, 20, 1, 1, 20, 0, 21, 1);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 1, 0, 0, 0, 0);
    cur = mk(1, 20, 0, 22, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 1, 20);
    // reset while holding B with busy {3,12}; pair reissues from A afterwards
    cur = mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    cur = mk(1, 0, 0, 3, 1, 1, 12, 0, 24, 1);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    do_reset(1, 12);
    run_cycle(1, 0, 0, 0, 0, 0, 0);

    need_new = 1;
    for (int i = 0; i < 1500; i++) begin
      if (need_new) cur = rand_pair();
      run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7));
      need_new = last_ready;
    end

    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 0);
    chk("A_queue_drained", qa.size(), 0);
    chk("B_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Dual-issue issue stage sitting directly upstream of the two-port-pair register file. Accepts a decoded instruction pair (slots A and B) and tracks pending destination registers in a 32-entry busy scoreboard. Each cycle it decides whether to issue A, A and B, or nothing, then drives the register-file read addresses. It emits execute-valid strobes aligned with the register file's one-cycle read data.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.
- REG_ADDR_W, 5, register address width.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- pair_valid_i  in  1  decode presents a pair.
- pair_ready_o  out  1  pair fully consumed this cycle.
- A_valid_i, B_valid_i  in  1  each slot holds an instruction.
- A_rs1_addr_i, A_rs2_addr_i, A_rd_addr_i  in  5  slot A operands and destination.
- A_rd_write_i  in  1  slot A writes rd.
- B_rs1_addr_i, B_rs2_addr_i, B_rd_addr_i  in  5  slot B operands and destination.
- B_rd_write_i  in  1  slot B writes rd.
- exec_stall_i  in  1  execute cannot accept; issue nothing.
- flush_i  in  1  drop the current pair and the hold state.
- A_wb_addr_i, B_wb_addr_i  in  5  writeback destinations.
- A_wb_write_i, B_wb_write_i  in  1  writeback strobes; these clear busy bits.
- A_issue_o, B_issue_o  out  1  slot issues this cycle (combinational).
- A_rs1_addr_o, A_rs2_addr_o, B_rs1_addr_o, B_rs2_addr_o  out  5  register-file read addresses; these pass through the slot inputs.
- A_ex_valid_o, B_ex_valid_o  out  1  registered issue strobes, aligned with read data.
- A_ex_rd_o, B_ex_rd_o  out  5  registered destinations.
- A_ex_rd_write_o, B_ex_rd_write_o  out  1  registered write enables.

## Operation
- Busy vector: 32 bits.
  - A bit is set at the edge when a slot issues with rd_write=1 and rd≠0.
  - A bit is cleared at the edge by a writeback with wb_write=1 and wb_addr≠0.
  - Bit 0 is never set.
  - If set and clear hit the same register in one cycle, set wins.
  - A writeback to a non-busy register has no effect.
- Effective busy: busy & ~(same-cycle writeback clear mask). Writeback data is visible to a same-cycle register-file read, so a same-cycle clear does not block issue.
- Slot hazard: the slot is blocked if any of its rs1, rs2, or rd (WAW, only when rd_write) is effectively busy. Address 0 never hazards.
- Intra-pair hazard: B is blocked by A when A_rd_write=1, A_rd≠0, and A_rd equals B_rs1, B_rs2, or (with B_rd_write) B_rd.
- Issue enable: en = pair_valid_i & ~exec_stall_i & ~flush_i.
- FSM states:
  - ISSUE_PAIR: both slots are live.
  - HOLD_B: A already issued; slot A inputs are ignored and treated invalid.
- In ISSUE_PAIR:
  - A_issue = en & A_valid & ~hazA.
  - B_issue = en & B_valid & ~hazB & ~intra & (A_issue | ~A_valid). Issue is in order: B never passes a blocked A.
  - If A issues and B is valid but not issued, go to HOLD_B.
- In HOLD_B:
  - B_issue = en & B_valid & ~hazB.
  - When B issues, return to ISSUE_PAIR.
  - A's rd is now busy, so a dependent B waits for writeback through the normal path.
- pair_ready_o = en & (every valid remaining slot issues this cycle). A pair with both valid bits low is consumed immediately when en=1.
- flush_i: state goes to ISSUE_PAIR, nothing issues that cycle, and pair_ready_o=1. The busy vector is unchanged because in-flight writebacks still arrive.
- Read addresses are always driven from the slot inputs, whether or not the slot issues.

## Timing
- Issue decision and read addresses are combinational in the same cycle.
- ex_valid, ex_rd, and ex_rd_write are registered at the issue edge, one cycle of latency. They are valid in the same cycle the register file presents data.
- While exec_stall_i=1: ex_valid outputs go to 0 and no state changes except writeback clears.
- Reset (asynchronous assert, synchronous-edge release):
  - busy=0 and state=ISSUE_PAIR.
  - All ex_* outputs are 0.
  - Combinational outputs (A_issue_o, B_issue_o, pair_ready_o) are forced to 0 while reset_n_i=0.
- Reset mid-HOLD_B: the held B is dropped. Decode must re-present the pair.

## Structure
- Shared core package holds:
  - NUM_REGS and REG_ADDR_W.
  - The state enum issue_state_t {ISSUE_PAIR, HOLD_B}.
  - A reg_addr_t typedef.
- One sub-module, issue_hazard_check, instanced once per slot. Inputs: rs1, rs2, rd, rd_write, effective busy. Output: hazard.

## Test plan
- Independent pair (A: x1=x2+x3, B: x4=x5+x6), busy clear → A_issue=B_issue=1 and pair_ready=1. Next cycle ex_valid=11, ex_rd=1/4, busy={1,4}.
- B reads A's rd (A: rd=x7, B: rs1=x7):
  - Cycle 0: A issues, state=HOLD_B, pair_ready=0.
  - B stalls until A_wb_write with addr 7.
  - B issues in that same writeback cycle, and pair_ready=1.
- A rs2=x9 busy → neither slot issues and state stays ISSUE_PAIR. A B_wb to x9 the next cycle → both issue that cycle.
- Same-cycle issue with rd=x5 and writeback of x5 → busy[5]=1 afterwards (set wins). Writeback to x0 or to a non-busy x8 → busy unchanged.
- In HOLD_B, assert flush_i → no issue, pair_ready=1, state=ISSUE_PAIR, and busy still holds A's rd.
- Assert reset_n_i=0 mid-HOLD_B with busy={3,12}:
  - All outputs go to 0 immediately and busy=0.
  - After release, the same pair reissues from slot A.
